// File: rtl/fnd_scan_driver.sv
// Binary (0..9999) to BCD via serial double-dabble, shown on a 4-digit
// common-anode FND with a self-generated digit scan.
module fnd_scan_driver #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [13:0] i_value,
  input  logic        i_load,
  input  logic        i_en,
  output logic        o_busy,
  output logic [3:0]  o_digit,
  output logic [7:0]  o_fndfont
);

  // state  | meaning
  // IDLE   | waiting for i_load
  // CONV   | 14 double-dabble steps, one input bit per cycle, MSB first
  // COMMIT | accumulator copied to display registers in one cycle
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]    r_state;
  logic [3:0]    r_bitcnt;
  logic [13:0]   r_bin;
  logic [15:0]   r_acc;
  logic [15:0]   r_disp;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_digit;
  logic [7:0]    r_font;

  logic [13:0]   w_sat;
  logic [15:0]   w_adj;
  logic          w_unused_adj_msb;
  logic          w_tick;
  logic [3:0]    w_nib;
  logic          w_blank;

  function automatic logic [7:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 8'hC0;
      4'd1:    font = 8'hF9;
      4'd2:    font = 8'hA4;
      4'd3:    font = 8'hB0;
      4'd4:    font = 8'h99;
      4'd5:    font = 8'h92;
      4'd6:    font = 8'h82;
      4'd7:    font = 8'hF8;
      4'd8:    font = 8'h80;
      4'd9:    font = 8'h90;
      default: font = 8'hFF;
    endcase
  endfunction

  assign w_sat = (i_value > 14'd9999) ? 14'd9999 : i_value;

  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < 4; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
    end
  end

  // The thousands nibble never exceeds 9 after 14 shifts, so its adjusted MSB is dropped.
  assign w_unused_adj_msb = w_adj[15];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_bitcnt <= 4'd0;
      r_bin    <= 14'd0;
      r_acc    <= 16'd0;
      r_disp   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_bin    <= w_sat;
            r_acc    <= 16'd0;
            r_bitcnt <= 4'd13;
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc <= {w_adj[14:0], r_bin[13]};
          r_bin <= {r_bin[12:0], 1'b0};
          if (r_bitcnt == 4'd0) r_state <= S_COMMIT;
          else                  r_bitcnt <= r_bitcnt - 4'd1;
        end
        S_COMMIT: begin
          r_disp  <= r_acc;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);

  assign w_tick = (r_presc == PW'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Leading-zero blanking: a digit is dark when it and everything above it is zero.
  always_comb begin
    w_nib   = r_disp[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin w_nib = r_disp[3:0];   w_blank = 1'b0;                   end
      2'd1: begin w_nib = r_disp[7:4];   w_blank = (r_disp[15:4] == 12'd0); end
      2'd2: begin w_nib = r_disp[11:8];  w_blank = (r_disp[15:8] == 8'd0);  end
      2'd3: begin w_nib = r_disp[15:12]; w_blank = (r_disp[15:12] == 4'd0); end
      default: begin w_nib = 4'd0; w_blank = 1'b1; end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_digit <= 4'b1111;
      r_font  <= 8'hFF;
    end else begin
      r_digit <= i_en ? ~(4'b0001 << r_idx) : 4'b1111;
      r_font  <= (i_en && !w_blank) ? font(w_nib) : 8'hFF;
    end
  end

  assign o_digit   = r_digit;
  assign o_fndfont = r_font;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver with DIV=4 (CLK_HZ=16, SCAN_HZ=4).
module tb_fnd_scan_driver;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] i_value;
  logic        i_load;
  logic        i_en;
  logic        o_busy;
  logic [3:0]  o_digit;
  logic [7:0]  o_fndfont;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always #5 clk = ~clk;

  fnd_scan_driver #(.CLK_HZ(16), .SCAN_HZ(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_value(i_value), .i_load(i_load),
    .i_en(i_en), .o_busy(o_busy), .o_digit(o_digit), .o_fndfont(o_fndfont)
  );

  // Edges since reset release; the output after edge k shows index ((k-1)/4)%4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_digit(input int d, input logic [7:0] f, input string tag);
    logic [3:0] pat;
    bit hit;
    pat = ~(4'b0001 << d);
    hit = 0;
    for (int i = 0; i < 24 && !hit; i++) begin
      @(negedge clk);
      if (o_digit === pat) hit = 1;
    end
    chk({tag, "_sel"}, {12'd0, o_digit}, {12'd0, pat});
    chk({tag, "_font"}, {8'd0, o_fndfont}, {8'd0, f});
  endtask

  task automatic conv(input logic [13:0] v, output int nb);
    @(negedge clk);
    i_value = v;
    i_load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_load = 1'b0;
    nb = 0;
    while (o_busy === 1'b1 && nb < 40) begin
      nb++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    int hold;
    int exp_idx;
    logic [3:0] pat;

    rst_n = 1'b0; i_en = 1'b1; i_load = 1'b0; i_value = 14'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  {15'd0, o_busy},   16'd0);
    chk("rst_digit", {12'd0, o_digit},  16'h000F);
    chk("rst_font",  {8'd0, o_fndfont}, 16'h00FF);
    rst_n = 1'b1;
    wait_digit(0, 8'hC0, "t1_d0");
    wait_digit(1, 8'hFF, "t1_d1");
    wait_digit(2, 8'hFF, "t1_d2");
    wait_digit(3, 8'hFF, "t1_d3");

    conv(14'd1234, nb);
    chk("t2_busy_len", 16'(nb), 16'd15);
    wait_digit(0, 8'h99, "t2_d0");
    wait_digit(1, 8'hB0, "t2_d1");
    hold = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_digit === 4'b1101) hold++;
      else break;
    end
    chk("t2_hold", 16'(hold), 16'd4);
    wait_digit(2, 8'hA4, "t2_d2");
    wait_digit(3, 8'hF9, "t2_d3");

    conv(14'd7, nb);
    chk("t3_busy_len7", 16'(nb), 16'd15);
    wait_digit(0, 8'hF8, "t3_7_d0");
    wait_digit(1, 8'hFF, "t3_7_d1");
    wait_digit(3, 8'hFF, "t3_7_d3");
    conv(14'd0, nb);
    wait_digit(0, 8'hC0, "t3_0_d0");
    wait_digit(1, 8'hFF, "t3_0_d1");
    wait_digit(2, 8'hFF, "t3_0_d2");

    conv(14'd12000, nb);
    wait_digit(0, 8'h90, "t4_d0");
    wait_digit(1, 8'h90, "t4_d1");
    wait_digit(2, 8'h90, "t4_d2");
    wait_digit(3, 8'h90, "t4_d3");

    // load 42, then a load pulse aligned with the COMMIT edge must be dropped
    @(negedge clk);
    i_value = 14'd42; i_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_load = 1'b0;
    repeat (14) @(negedge clk);
    chk("commit_busy", {15'd0, o_busy}, 16'd1);
    i_value = 14'd9; i_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_load = 1'b0;
    chk("commit_load_ignored", {15'd0, o_busy}, 16'd0);
    wait_digit(0, 8'hA4, "commit_d0");
    wait_digit(1, 8'h99, "commit_d1");
    wait_digit(2, 8'hFF, "commit_d2");

    // load 1234, second load during busy cycle 5 is ignored
    @(negedge clk);
    i_value = 14'd1234; i_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_load = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_busy === 1'b1) nb++;
      if (i == 4) begin i_value = 14'd5678; i_load = 1'b1; end
      if (i == 5) i_load = 1'b0;
      @(negedge clk);
    end
    chk("t5_busy_len", 16'(nb), 16'd15);
    wait_digit(0, 8'h99, "t5_d0");
    wait_digit(1, 8'hB0, "t5_d1");
    wait_digit(2, 8'hA4, "t5_d2");
    wait_digit(3, 8'hF9, "t5_d3");

    @(negedge clk);
    i_en = 1'b0;
    @(negedge clk);
    chk("t5_off_digit", {12'd0, o_digit},  16'h000F);
    chk("t5_off_font",  {8'd0, o_fndfont}, 16'h00FF);
    repeat (5) @(negedge clk);
    chk("t5_off_digit2", {12'd0, o_digit}, 16'h000F);
    i_en = 1'b1;
    @(negedge clk);
    exp_idx = ((cyc - 1) / 4) % 4;
    pat = ~(4'b0001 << exp_idx);
    chk("t5_scan_kept", {12'd0, o_digit}, {12'd0, pat});

    @(negedge clk);
    i_value = 14'd4321; i_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_load = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  {15'd0, o_busy},   16'd0);
    chk("t6_rst_digit", {12'd0, o_digit},  16'h000F);
    chk("t6_rst_font",  {8'd0, o_fndfont}, 16'h00FF);
    @(negedge clk);
    rst_n = 1'b1;
    wait_digit(0, 8'hC0, "t6_d0");
    wait_digit(1, 8'hFF, "t6_d1");
    wait_digit(3, 8'hFF, "t6_d3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
